vga_timing: RTL and testbench
=============================

# vga_timing

Raster timing generator and video output stage. It produces the pixel coordinate stream (`pix_x`, `pix_y`, `pix_v`, `frame_id`) consumed by the pixel generators, such as the frog sprite renderer. It also accepts their `color[2:0]` return and drives the VGA DAC pins. Sync signals are delayed to match the generator's color latency, so the DAC sees aligned color, hsync and vsync.

## Interface
- `pA`, 10: coordinate/counter width; `H_TOTAL`, `V_TOTAL` must be ≤ 2^pA
- `fA`, 32: frame counter width
- `cA`, 4: bits per color channel
- `CLK_DIV`, 2: system clocks per pixel (50 MHz → 25 MHz pixel rate); ≥ 1
- `LAT`, 1: pixel-generator latency in pixel ticks, 0..4
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33
- `SYNC_NEG`, 1: 1 = sync pulses active-low

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `pix_x` out pA: column, 0..H_ACTIVE-1 while active, 0 otherwise
- `pix_y` out pA: row, 0..V_ACTIVE-1 while active, 0 otherwise
- `pix_v` out 1: coordinate is inside the visible area
- `frame_id` out fA: completed-frame count
- `pix_ce` out 1: one-clock pulse marking each pixel tick
- `color` in cA ×3 (`[2:0]`): generator return; [2]=R, [1]=G, [0]=B
- `vga_r`, `vga_g`, `vga_b` out cA each: DAC drive
- `vga_hs`, `vga_vs` out 1: sync pins

## Operation
- **Prescaler.** Counts 0..CLK_DIV-1 and asserts `pix_ce` when it reaches CLK_DIV-1. With CLK_DIV=1, `pix_ce` is constantly 1 after reset.
- **Counters.** On `pix_ce`, `h_cnt` advances and wraps at H_TOTAL-1 → 0 (H_TOTAL = sum of H params).
  - On an h wrap, `v_cnt` advances and wraps at V_TOTAL-1 → 0.
  - On a simultaneous h and v wrap, `frame_id` increments, wrapping modulo 2^fA.
- **Coordinate outputs.** Registered from the next counter values:
  - `pix_v` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - `pix_x`/`pix_y` carry the counters when `pix_v`=1, otherwise 0.
- **Raw syncs.** hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751]. vsync is asserted for v in [490,491]. Polarity comes from SYNC_NEG.
- **Delay line.** {pix_v, hs, vs} pass through a LAT-stage shift register clocked by `pix_ce`.
- **Output register.** On `pix_ce`, `color` is sampled into `vga_r/g/b` when the delayed `pix_v` is 1, and forced to 0 otherwise. `vga_hs`/`vga_vs` take the delayed syncs on the same tick.
- **Input handling.** `color` is ignored outside the sampling tick. No clamping is applied.

## Timing
- **Reset values** (asynchronous, `rst`=0):
  - prescaler, counters, `frame_id` = 0
  - `pix_x`, `pix_y`, `vga_*` colors = 0
  - `pix_v` = 0, `pix_ce` = 0
  - `vga_hs`/`vga_vs` deasserted (1 when SYNC_NEG)
  - delay line cleared to blank with syncs deasserted
- **After reset release:**
  - The first `pix_ce` fires on the CLK_DIV-th rising edge.
  - On that tick the outputs present h=0, v=0 (`pix_v`=1, x=0, y=0).
- **Output alignment.**
  - Coordinates change only on `pix_ce` edges.
  - The `color` for coordinate N must be valid at the (LAT+1)-th `pix_ce` after that coordinate was presented.
  - It reaches the DAC on that tick, in the same cycle as the matching delayed sync.
- **Frame counter.** `frame_id` changes on the tick on which x=0, y=0 is presented, after h=799, v=524.
- **Reset mid-frame.** All state returns to reset values immediately. The next frame starts at h=0, v=0 with no partial sync pulse.
- **Frame geometry.** 800×525 pixel ticks per frame; line period 800 ticks.

## Structure
- **`vga_pkg`:** default timing localparams, derived H_TOTAL/V_TOTAL and sync start/end constants, and typedef `sync_t` = struct {vis, hs, vs}.
- **Sub-module `vga_delay`:** parameterised LAT-deep `sync_t` shift register with a clock enable. LAT=0 must be a pass-through.

## Test plan
- **Reset and first tick.** Reset, release, CLK_DIV=2 → `pix_ce` first on the 2nd edge; x=0, y=0, `pix_v`=1, `vga_hs`=1, `frame_id`=0.
- **Line timing.** Run one line → `pix_v` falls at h=640, `vga_hs` low for exactly 96 ticks starting LAT+1 ticks after h=656, line repeats every 800 ticks (1600 clocks).
- **Frame timing.** Run two frames → `vga_vs` low for 2 lines (1600 ticks) per frame, `frame_id` 0→1→2, 420000 ticks per frame.
- **Latency and blanking.** Model the generator with LAT=1, returning color = {x[3:0], y[3:0], 4'hA} → DAC shows the matching value aligned to the tick, and 0 during blanking even while `color`=12'hFFF.
- **Wrap and config.** Force `frame_id` to 2^fA-1 → wraps to 0. CLK_DIV=1, LAT=0 → `pix_ce` constant 1 and color passes through on the next edge.
- **Mid-frame reset.** Assert `rst` at h=300, v=200 → all outputs at reset values asynchronously, and the next frame restarts at 0,0.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster geometry, derived totals/sync windows and the
// per-pixel sync bundle carried through the colour-latency delay line.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF   = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF     = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF   = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF     = VS_START_DEF + V_SYNC_DEF - 1;

  // hs/vs are logical "asserted" flags; pin polarity is applied at the output.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{vis: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/vga_delay.sv
// LAT-deep shift register for the sync bundle, advanced on the pixel tick.
// LAT=0 degenerates to a wire.
module vga_delay
  import vga_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  sync_t d,
  output sync_t q
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, en};
      assign q = d;
    end else begin : g_pipe
      sync_t stage [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) stage[i] <= SYNC_IDLE;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel prescaler, h/v counters, coordinate outputs,
// and a DAC output stage whose syncs are delayed to match generator latency.
module vga_timing
  import vga_pkg::*;
#(
  parameter int pA       = 10,
  parameter int fA       = 32,
  parameter int cA       = 4,
  parameter int CLK_DIV  = 2,
  parameter int LAT      = 1,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_NEG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [pA-1:0]          pix_x,
  output logic [pA-1:0]          pix_y,
  output logic                   pix_v,
  output logic [fA-1:0]          frame_id,
  output logic                   pix_ce,
  input  logic [2:0][cA-1:0]     color,
  output logic [cA-1:0]          vga_r,
  output logic [cA-1:0]          vga_g,
  output logic [cA-1:0]          vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          SYNC_OFF = (SYNC_NEG != 0);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [pA-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic          primed, h_wrap, v_wrap;
  sync_t         raw_s, cur_s, dly_s;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce  <= tick;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // The counters hold the coordinate currently presented; the first tick after
  // reset presents 0,0 without advancing, so later ticks advance before presenting.
  always_comb begin
    h_wrap = primed && (h_cnt == pA'(H_TOTAL - 1));
    v_wrap = h_wrap && (v_cnt == pA'(V_TOTAL - 1));
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (primed) begin
      h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
    end
    raw_s.vis = (h_nxt < pA'(H_ACTIVE)) && (v_nxt < pA'(V_ACTIVE));
    raw_s.hs  = (h_nxt >= pA'(HS_START)) && (h_nxt <= pA'(HS_END));
    raw_s.vs  = (v_nxt >= pA'(VS_START)) && (v_nxt <= pA'(VS_END));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed   <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      frame_id <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      cur_s    <= SYNC_IDLE;
    end else if (tick) begin
      primed <= 1'b1;
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
      if (v_wrap) frame_id <= frame_id + 1'b1;
      pix_x  <= raw_s.vis ? h_nxt : '0;
      pix_y  <= raw_s.vis ? v_nxt : '0;
      cur_s  <= raw_s;
    end
  end

  assign pix_v = cur_s.vis;

  vga_delay #(.LAT(LAT)) u_delay (
    .clk   (clk),
    .rst_n (rst),
    .en    (tick),
    .d     (cur_s),
    .q     (dly_s)
  );

  // Colour and syncs for the same coordinate land on the DAC on one tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= SYNC_OFF;
      vga_vs <= SYNC_OFF;
    end else if (tick) begin
      vga_r  <= dly_s.vis ? color[2] : '0;
      vga_g  <= dly_s.vis ? color[1] : '0;
      vga_b  <= dly_s.vis ? color[0] : '0;
      vga_hs <= dly_s.hs ^ SYNC_OFF;
      vga_vs <= dly_s.vs ^ SYNC_OFF;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: three configurations (default 640x480, small raster with
// LAT=2/fA=2, small raster with CLK_DIV=1/LAT=0/positive syncs).
module tb_vga_timing;

  localparam int S_X = 0, S_Y = 1, S_V = 2, S_FID = 3, S_R = 4, S_G = 5, S_B = 6,
                 S_HS = 7, S_VS = 8;

  typedef struct packed {
    int     tick;
    int     sig;
    longint exp;
  } vec_t;

  logic              clk;
  logic              rstv [3];
  logic [9:0]        px [3];
  logic [9:0]        py [3];
  logic              pv [3];
  logic              pce [3];
  logic [2:0][3:0]   col [3];
  logic [3:0]        vr [3];
  logic [3:0]        vg [3];
  logic [3:0]        vb [3];
  logic              hs [3];
  logic              vs [3];
  logic [31:0]       fid0, fid2;
  logic [1:0]        fid1;

  vec_t   sbq [3][$];
  int     tk [3];
  int     n_vec = 0;
  int     n_miss = 0;
  int     ce2_gaps = 0;
  bit     seen2 = 0;
  logic [11:0] g0;

  vga_timing dut0 (
    .clk(clk), .rst(rstv[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_v(pv[0]),
    .frame_id(fid0), .pix_ce(pce[0]), .color(col[0]), .vga_r(vr[0]),
    .vga_g(vg[0]), .vga_b(vb[0]), .vga_hs(hs[0]), .vga_vs(vs[0])
  );

  vga_timing #(
    .fA(2), .CLK_DIV(2), .LAT(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut1 (
    .clk(clk), .rst(rstv[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_v(pv[1]),
    .frame_id(fid1), .pix_ce(pce[1]), .color(col[1]), .vga_r(vr[1]),
    .vga_g(vg[1]), .vga_b(vb[1]), .vga_hs(hs[1]), .vga_vs(vs[1])
  );

  vga_timing #(
    .CLK_DIV(1), .LAT(0), .SYNC_NEG(0), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
    .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut2 (
    .clk(clk), .rst(rstv[2]), .pix_x(px[2]), .pix_y(py[2]), .pix_v(pv[2]),
    .frame_id(fid2), .pix_ce(pce[2]), .color(col[2]), .vga_r(vr[2]),
    .vga_g(vg[2]), .vga_b(vb[2]), .vga_hs(hs[2]), .vga_vs(vs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] fcol(int d);
    return pv[d] ? {px[d][3:0], py[d][3:0], 4'hA} : 12'hFFF;
  endfunction

  function automatic longint get_sig(int d, int s);
    case (s)
      S_X:     return longint'(px[d]);
      S_Y:     return longint'(py[d]);
      S_V:     return longint'(pv[d]);
      S_FID:   return (d == 0) ? longint'(fid0) : (d == 1) ? longint'(fid1) : longint'(fid2);
      S_R:     return longint'(vr[d]);
      S_G:     return longint'(vg[d]);
      S_B:     return longint'(vb[d]);
      S_HS:    return longint'(hs[d]);
      S_VS:    return longint'(vs[d]);
      default: return -1;
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      S_X: return "pix_x";   S_Y: return "pix_y";   S_V: return "pix_v";
      S_FID: return "frame_id"; S_R: return "vga_r"; S_G: return "vga_g";
      S_B: return "vga_b";   S_HS: return "vga_hs"; S_VS: return "vga_vs";
      default: return "?";
    endcase
  endfunction

  task automatic check(string nm, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(int d, int t, int s, longint e);
    vec_t v;
    v.tick = t;
    v.sig  = s;
    v.exp  = e;
    sbq[d].push_back(v);
  endtask

  task automatic wait_empty(int budget);
    int c = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check("sb_timeout_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
  endtask

  // Generator models: dut0 answers one tick late (LAT=1), dut2 immediately.
  always @(negedge clk) begin
    col[1] = 12'h777;
    if (!rstv[0]) begin
      col[0] = '0;
      g0 = '0;
    end else if (pce[0]) begin
      col[0] = g0;
      g0 = fcol(0);
    end
    if (!rstv[2]) col[2] = '0;
    else if (pce[2]) col[2] = fcol(2);
  end

  // Monitor: tick k = k-th pix_ce cycle since reset release.
  always @(negedge clk) begin
    vec_t e;
    for (int d = 0; d < 3; d++) begin
      if (!rstv[d]) tk[d] = 0;
      else if (pce[d]) begin
        tk[d]++;
        while (sbq[d].size() > 0 && sbq[d][0].tick == tk[d]) begin
          e = sbq[d].pop_front();
          check($sformatf("d%0d_t%0d_%s", d, e.tick, sig_name(e.sig)), get_sig(d, e.sig), e.exp);
        end
      end
    end
    if (rstv[2] && seen2 && !pce[2]) ce2_gaps++;
    if (rstv[2] && pce[2]) seen2 = 1;
  end

  initial begin
    int c;
    for (int d = 0; d < 3; d++) begin
      rstv[d] = 1'b0;
      tk[d] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_pix_x", px[0], 0);
    check("rst_pix_v", pv[0], 0);
    check("rst_pix_ce", pce[0], 0);
    check("rst_vga_hs_neg", hs[0], 1);
    check("rst_vga_vs_neg", vs[0], 1);
    check("rst_vga_r", vr[0], 0);
    check("rst_frame_id", fid0, 0);
    check("rst_vga_hs_pos", hs[2], 0);

    // dut0: 640x480, CLK_DIV=2, LAT=1; DAC at tick k shows coordinate k-3
    push(0, 1, S_X, 0);   push(0, 1, S_Y, 0);   push(0, 1, S_V, 1);
    push(0, 1, S_HS, 1);  push(0, 1, S_FID, 0);
    push(0, 2, S_R, 0);   push(0, 2, S_HS, 1);
    push(0, 3, S_R, 0);   push(0, 3, S_G, 0);   push(0, 3, S_B, 10);
    push(0, 13, S_R, 10); push(0, 13, S_G, 0);  push(0, 13, S_B, 10);
    push(0, 640, S_X, 639); push(0, 640, S_V, 1);
    push(0, 641, S_X, 0); push(0, 641, S_V, 0);
    push(0, 643, S_R, 0); push(0, 643, S_G, 0); push(0, 643, S_B, 0);
    push(0, 658, S_HS, 1); push(0, 659, S_HS, 0);
    push(0, 754, S_HS, 0); push(0, 755, S_HS, 1); push(0, 755, S_VS, 1);
    push(0, 801, S_X, 0); push(0, 801, S_Y, 1); push(0, 801, S_V, 1); push(0, 801, S_FID, 0);
    push(0, 808, S_R, 5); push(0, 808, S_G, 1); push(0, 808, S_B, 10);
    push(0, 1458, S_HS, 1); push(0, 1459, S_HS, 0);

    // dut1: 16x8 raster, LAT=2, fA=2; DAC at tick k shows coordinate k-4
    push(1, 1, S_X, 0);   push(1, 1, S_Y, 0);   push(1, 1, S_V, 1);
    push(1, 1, S_FID, 0); push(1, 1, S_VS, 1);
    push(1, 3, S_VS, 1);  push(1, 3, S_HS, 1);
    push(1, 8, S_X, 7);   push(1, 8, S_V, 1);   push(1, 9, S_V, 0);
    push(1, 13, S_HS, 1); push(1, 14, S_HS, 0); push(1, 16, S_HS, 0); push(1, 17, S_HS, 1);
    push(1, 49, S_Y, 3);  push(1, 49, S_V, 1);  push(1, 65, S_V, 0); push(1, 65, S_Y, 0);
    push(1, 83, S_VS, 1); push(1, 84, S_VS, 0); push(1, 115, S_VS, 0); push(1, 116, S_VS, 1);
    push(1, 128, S_FID, 0); push(1, 129, S_FID, 1); push(1, 129, S_X, 0); push(1, 129, S_Y, 0);
    push(1, 257, S_FID, 2); push(1, 385, S_FID, 3); push(1, 512, S_FID, 3); push(1, 513, S_FID, 0);

    // dut2: CLK_DIV=1, LAT=0, positive syncs; DAC at tick k shows coordinate k-2
    push(2, 1, S_X, 0);   push(2, 1, S_V, 1);   push(2, 1, S_HS, 0);
    push(2, 3, S_R, 1);   push(2, 3, S_G, 0);   push(2, 3, S_B, 10);
    push(2, 10, S_R, 0);  push(2, 10, S_B, 0);
    push(2, 11, S_HS, 0); push(2, 12, S_HS, 1); push(2, 14, S_HS, 1); push(2, 15, S_HS, 0);
    push(2, 21, S_R, 3);  push(2, 21, S_G, 1);  push(2, 21, S_B, 10);
    push(2, 81, S_VS, 0); push(2, 82, S_VS, 1); push(2, 113, S_VS, 1); push(2, 114, S_VS, 0);
    push(2, 129, S_FID, 1);

    @(negedge clk);
    for (int d = 0; d < 3; d++) rstv[d] = 1'b1;
    @(posedge clk); #1;
    check("ce_edge1_div2", pce[0], 0);
    check("ce_edge1_div1", pce[2], 1);
    @(posedge clk); #1;
    check("ce_edge2_div2", pce[0], 1);

    wait_empty(4000);

    // Reset dut1 in the middle of a vsync pulse of frame 3
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!(pce[1] && (tk[1] % 512) == 484) && c < 1200);
    check("mid_wait_expired", (c < 1200) ? 1 : 0, 1);
    check("mid_vs_before", vs[1], 0);
    check("mid_fid_before", fid1, 3);
    #1 rstv[1] = 1'b0;
    #1;
    check("mid_rst_pix_ce", pce[1], 0);
    check("mid_rst_vga_vs", vs[1], 1);
    check("mid_rst_vga_hs", hs[1], 1);
    check("mid_rst_frame_id", fid1, 0);
    check("mid_rst_pix_v", pv[1], 0);

    push(1, 1, S_X, 0);   push(1, 1, S_Y, 0);   push(1, 1, S_V, 1);
    push(1, 1, S_FID, 0); push(1, 1, S_VS, 1);  push(1, 1, S_HS, 1);
    push(1, 2, S_VS, 1);  push(1, 4, S_VS, 1);
    push(1, 84, S_VS, 0); push(1, 116, S_VS, 1); push(1, 129, S_FID, 1);
    repeat (3) @(negedge clk);
    rstv[1] = 1'b1;
    wait_empty(2000);

    check("div1_ce_gaps", ce2_gaps, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
